// File: rtl/gobou_ctrl_pkg.sv
// Shared constants and types for the gobou layer sequencer.
//   LWIDTH  : width of the layer size fields (in_size/out_size)
//   MEMSIZE : address width of the input, weight and output memories
//   MEM_LAT : cycles from address issue to x/w valid at the MAC inputs
//   MAC_LAT : cycles from MAC input to product valid at the accumulator
//   STEP    : clock period used by the benches
//   ctrl_state_t : sequencer state encoding
package gobou_ctrl_pkg;

    localparam int unsigned LWIDTH  = 10;
    localparam int unsigned MEMSIZE = 12;
    localparam int unsigned MEM_LAT = 1;
    localparam int unsigned MAC_LAT = 2;
    localparam int unsigned STEP    = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT,
        S_CLEAR
    } ctrl_state_t;

endpackage

// File: rtl/gobou_ctrl_delay.sv
// DEPTH-stage 1-bit shift register with synchronous clear.
//   clk     : clock
//   clear   : synchronous clear of every stage
//   din     : bit entering stage 0
//   dout    : bit leaving the last stage (din delayed by DEPTH cycles)
//   pending : a set bit sits in a stage other than the last one, i.e. the
//             line will still be non-empty next cycle
module gobou_ctrl_delay #(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic clear,
    input  logic din,
    output logic dout,
    output logic pending
);

    logic [DEPTH-1:0] line_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            line_q <= '0;
        end else begin
            line_q[0] <= din;
            for (int k = 1; k < int'(DEPTH); k++) begin
                line_q[k] <= line_q[k-1];
            end
        end
    end

    always_comb begin
        pending = 1'b0;
        for (int k = 0; k < int'(DEPTH) - 1; k++) begin
            pending = pending | line_q[k];
        end
    end

    assign dout = line_q[DEPTH-1];

endmodule

// File: rtl/gobou_ctrl.sv
// Layer sequencer for the gobou fully-connected engine.
// On req (while idle) walks every output neuron: issues input/weight read
// addresses, drives the gobou_mac strobes aligned to the memory+MAC pipeline,
// and writes each finished neuron back to the output buffer.
//   clk, xrst            : clock, synchronous active-high reset
//   req                  : start pulse, honoured only while ack=1
//   in_size, out_size    : inputs per neuron / number of neurons (latched)
//   in_offset, w_offset, out_offset : memory base addresses (latched)
//   ack                  : 1 = idle/ready
//   mem_in_addr, mem_w_addr : input buffer / weight memory read addresses
//   mem_out_we, mem_out_addr : output buffer write strobe and address
//   mac_accum_we, mac_out_en, mac_reset : gobou_mac control strobes
module gobou_ctrl
    import gobou_ctrl_pkg::*;
#(
    parameter int unsigned LWIDTH  = gobou_ctrl_pkg::LWIDTH,
    parameter int unsigned MEMSIZE = gobou_ctrl_pkg::MEMSIZE,
    parameter int unsigned MEM_LAT = gobou_ctrl_pkg::MEM_LAT,
    parameter int unsigned MAC_LAT = gobou_ctrl_pkg::MAC_LAT
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               req,
    input  logic [LWIDTH-1:0]  in_size,
    input  logic [LWIDTH-1:0]  out_size,
    input  logic [MEMSIZE-1:0] in_offset,
    input  logic [MEMSIZE-1:0] w_offset,
    input  logic [MEMSIZE-1:0] out_offset,
    output logic               ack,
    output logic [MEMSIZE-1:0] mem_in_addr,
    output logic [MEMSIZE-1:0] mem_w_addr,
    output logic               mem_out_we,
    output logic [MEMSIZE-1:0] mem_out_addr,
    output logic               mac_accum_we,
    output logic               mac_out_en,
    output logic               mac_reset
);

    // Issue-to-accumulate distance through memory read and MAC stages.
    localparam int unsigned D = MEM_LAT + MAC_LAT;

    ctrl_state_t        state_q, state_d;
    logic [LWIDTH-1:0]  i_q, i_d;
    logic [LWIDTH-1:0]  o_q, o_d;
    logic [LWIDTH-1:0]  n_q, n_d;
    logic [LWIDTH-1:0]  m_q, m_d;
    logic [MEMSIZE-1:0] in_off_q, in_off_d;
    logic [MEMSIZE-1:0] out_off_q, out_off_d;
    // Weight pointer runs across neurons, so neuron o reads w_offset+o*N+i
    // without a multiplier.
    logic [MEMSIZE-1:0] w_ptr_q, w_ptr_d;
    logic               issue;
    logic               pending;

    always_ff @(posedge clk) begin
        if (xrst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            o_q       <= '0;
            n_q       <= '0;
            m_q       <= '0;
            in_off_q  <= '0;
            out_off_q <= '0;
            w_ptr_q   <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            o_q       <= o_d;
            n_q       <= n_d;
            m_q       <= m_d;
            in_off_q  <= in_off_d;
            out_off_q <= out_off_d;
            w_ptr_q   <= w_ptr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        o_d          = o_q;
        n_d          = n_q;
        m_d          = m_q;
        in_off_d     = in_off_q;
        out_off_d    = out_off_q;
        w_ptr_d      = w_ptr_q;
        ack          = 1'b0;
        issue        = 1'b0;
        mem_in_addr  = '0;
        mem_w_addr   = '0;
        mem_out_we   = 1'b0;
        mem_out_addr = '0;
        mac_out_en   = 1'b0;
        mac_reset    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ack = 1'b1;
                // An empty layer is simply not started.
                if (req && (in_size != '0) && (out_size != '0)) begin
                    n_d       = in_size;
                    m_d       = out_size;
                    in_off_d  = in_offset;
                    out_off_d = out_offset;
                    w_ptr_d   = w_offset;
                    i_d       = '0;
                    o_d       = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue       = 1'b1;
                mem_in_addr = in_off_q + MEMSIZE'(i_q);
                mem_w_addr  = w_ptr_q;
                w_ptr_d     = w_ptr_q + MEMSIZE'(1);
                if (i_q == n_q - LWIDTH'(1)) begin
                    i_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    i_d = i_q + LWIDTH'(1);
                end
            end
            S_DRAIN: begin
                // Leave once only the last stage may still hold a flag, so
                // out_en lands on the cycle right after the last accumulate.
                if (!pending) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                mac_out_en = 1'b1;
                state_d    = S_CLEAR;
            end
            S_CLEAR: begin
                mac_reset    = 1'b1;
                mem_out_we   = 1'b1;
                mem_out_addr = out_off_q + MEMSIZE'(o_q);
                if (o_q == m_q - LWIDTH'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    o_d     = o_q + LWIDTH'(1);
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    gobou_ctrl_delay #(
        .DEPTH(D)
    ) u_delay (
        .clk    (clk),
        .clear  (xrst),
        .din    (issue),
        .dout   (mac_accum_we),
        .pending(pending)
    );

endmodule

// File: doc/gobou_ctrl.md
Name: gobou_ctrl

Overview:
- Layer sequencer for the gobou fully-connected engine.
- On a start request, walks every output neuron of the layer. For each neuron it:
  - issues input-buffer and weight-memory read addresses;
  - drives the gobou_mac control strobes (accum_we, out_en, reset), delayed to match the memory and MAC pipeline;
  - writes the finished neuron value back to the output buffer.
- Sits between the top-level layer FSM (req/ack) and the memories plus gobou_mac.

Parameters:
- LWIDTH, 10: width of the layer size fields in_size and out_size.
- MEMSIZE, 12: address width of the input, weight and output memories.
- MEM_LAT, 1: read latency in cycles from address issue to x/w valid at the MAC inputs.
- MAC_LAT, 2: cycles from MAC input to product valid at the accumulator (register stage x$/w$ plus product stage).

Ports:
- clk  in  1  clock.
- xrst  in  1  reset; synchronous, active-high.
- req  in  1  start pulse; sampled only while ack=1.
- in_size  in  LWIDTH  number of inputs per neuron; latched on start.
- out_size  in  LWIDTH  number of output neurons; latched on start.
- in_offset  in  MEMSIZE  input buffer base address.
- w_offset  in  MEMSIZE  weight memory base address.
- out_offset  in  MEMSIZE  output buffer base address.
- ack  out  1  1 = idle/ready, 0 = busy.
- mem_in_addr  out  MEMSIZE  input buffer read address.
- mem_w_addr  out  MEMSIZE  weight memory read address.
- mem_out_we  out  1  output buffer write enable.
- mem_out_addr  out  MEMSIZE  output buffer write address.
- mac_accum_we  out  1  to gobou_mac accum_we.
- mac_out_en  out  1  to gobou_mac out_en.
- mac_reset  out  1  to gobou_mac reset.

Behaviour:
- Reset and timing constants
  - xrst=1 at an edge sets: state S_IDLE, ack=1, all strobes 0, all addresses 0, delay line cleared.
  - Reset applies mid-operation too. Strobes are 0 from the following cycle, and in-flight work is discarded.
  - D = MEM_LAT + MAC_LAT (default 3). N = latched in_size.
- States: S_IDLE, S_ISSUE, S_DRAIN, S_OUT, S_CLEAR.
- S_IDLE
  - ack=1.
  - req=1 latches the sizes and offsets and moves to S_ISSUE. ack drops to 0 the next cycle (cycle s).
  - If the latched in_size=0 or out_size=0, stay in S_IDLE with ack=1 and emit no strobes.
- S_ISSUE (cycles s..s+N-1)
  - mem_in_addr = in_offset+i.
  - mem_w_addr = running weight pointer. It starts at w_offset, increments every issue cycle, and carries across neurons: neuron o uses w_offset + o*N + i. No multiplier is used.
  - An issue flag enters a D-deep shift register.
  - After i = N-1, go to S_DRAIN.
- Accumulate window: mac_accum_we = issue flag delayed by D. It is high for cycles s+D .. s+D+N-1.
- S_DRAIN: wait until the delay line is empty.
- S_OUT: mac_out_en=1 for exactly cycle s+D+N.
- S_CLEAR (cycle s+D+N+1)
  - mac_reset=1 and mem_out_we=1 in the same cycle; y is valid then.
  - mem_out_addr = out_offset+o.
  - If o < out_size-1: increment o, reset i, and the next S_ISSUE starts at cycle s+D+N+2.
  - Otherwise go to S_IDLE; ack=1 the following cycle.
- Per-neuron period is N+D+2 cycles. Neurons never overlap.
- Width and overflow rules
  - Address arithmetic is modulo 2^MEMSIZE; wrap is silent.
  - in_size/out_size of all ones (2^LWIDTH-1) must work; counters are LWIDTH bits wide.
- Concurrency
  - req while ack=0 is ignored.
  - Offset and size inputs may change while busy with no effect.
- Strobe exclusivity: mac_accum_we, mac_out_en and mac_reset are never high in the same cycle.

Decomposition:
- gobou.svh package holds LWIDTH, MEMSIZE, MEM_LAT, MAC_LAT, the state enum ctrl_state_t, and STEP for the benches.
- One sub-module, gobou_ctrl_delay: a parameterised D-stage 1-bit shift register with synchronous clear. It generates mac_accum_we from the issue flag.

Test Plan:
- Basic run, in_size=4, out_size=2, req at cycle 0, default D=3:
  - issue cycles 1-4 and 10-13;
  - accum_we cycles 4-7 and 13-16;
  - out_en at 8 and 17;
  - reset+mem_out_we at 9 and 18, out addrs out_offset+0 and out_offset+1;
  - ack=1 at 19.
- Address walk, w_offset=100, in_offset=20, in_size=3, out_size=3: mem_w_addr sequence 100..108 contiguous; mem_in_addr repeats 20,21,22 three times.
- End to end with gobou_mac and memories, x=i*256, w=i*256, i=0..4: stored y equals sum(i*i)*256 = 30*256 in Q8.
- Degenerate sizes, in_size=0 then out_size=0: ack stays 1 and no strobe or write is ever asserted.
- Request while busy, then mid-run reset:
  - req pulsed at cycle 5 of a run is ignored, and the sequence timing is unchanged;
  - xrst=1 at cycle 6 forces ack=1 and all strobes 0 from cycle 7;
  - a new req then restarts cleanly from neuron 0.
- Boundary size, in_size=1023, out_size=1: exactly 1023 accum_we cycles, then out_en at cycle 1+3+1023.
